// File: rtl/ucsbece154b_perf_counters.sv
// Performance-monitor block: free-running cycle counter plus NUM_EVENTS event counters, gated by
// an IDLE/RUN/FROZEN state machine, with snapshot shadows and a registered read port.
// Build option: define PERF_SATURATE_EN for saturating counters (default build wraps).
module ucsbece154b_perf_counters #(
  parameter int NUM_EVENTS = 5,
  parameter int CNT_WIDTH  = 32,
  parameter int SEL_W      = $clog2(NUM_EVENTS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  clear_i,
  input  logic                  snapshot_i,
  input  logic [NUM_EVENTS-1:0] event_i,
  input  logic [SEL_W-1:0]      rd_sel_i,
  output logic [CNT_WIDTH-1:0]  rd_data_o,
  output logic [NUM_EVENTS:0]   overflow_o,
  output logic                  snap_valid_o,
  output logic                  running_o
);

  localparam int NCNT = NUM_EVENTS + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2
  } state_e;

  state_e               state_r;
  logic                 running_r;
  logic                 snap_valid_r;
  logic [NCNT-1:0]      ovf_r;
  logic [CNT_WIDTH-1:0] rd_data_r;
  logic [CNT_WIDTH-1:0] cnt_r     [NCNT];
  logic [CNT_WIDTH-1:0] shadow_r  [NCNT];
  logic [CNT_WIDTH-1:0] cnt_nxt_s [NCNT];
  logic [NCNT-1:0]      inc_s;
  logic [NCNT-1:0]      ovf_set_s;
  logic [CNT_WIDTH-1:0] rd_mux_s;

  // Per-counter increment, next value, overflow detection and shadow read mux.
  always_comb begin
    inc_s     = (state_r == RUN) ? {event_i, 1'b1} : {NCNT{1'b0}};
    ovf_set_s = {NCNT{1'b0}};
    rd_mux_s  = CNT_ZERO;
    for (int k = 0; k < NCNT; k++) begin
      ovf_set_s[k] = inc_s[k] & (&cnt_r[k]);
`ifdef PERF_SATURATE_EN
      cnt_nxt_s[k] = (inc_s[k] && !ovf_set_s[k]) ? (cnt_r[k] + CNT_ONE) : cnt_r[k];
`else
      cnt_nxt_s[k] = inc_s[k] ? (cnt_r[k] + CNT_ONE) : cnt_r[k];
`endif
      // Selects beyond NUM_EVENTS match no entry and fall through to zero.
      rd_mux_s = (rd_sel_i == SEL_W'(k)) ? shadow_r[k] : rd_mux_s;
    end
  end

  // Control state machine; running_r is the registered copy of (state == RUN).
  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      state_r   <= IDLE;
      running_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_i) begin
            state_r   <= RUN;
            running_r <= 1'b1;
          end
        end
        RUN: begin
          if (stop_i) begin
            state_r   <= FROZEN;
            running_r <= 1'b0;
          end
        end
        FROZEN: begin
          if (start_i) begin
            state_r   <= RUN;
            running_r <= 1'b1;
          end
        end
        default: begin
          state_r   <= IDLE;
          running_r <= 1'b0;
        end
      endcase
    end
  end

  // Live counters, sticky overflow flags and snapshot shadows (shadows take pre-increment values).
  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      for (int k = 0; k < NCNT; k++) begin
        cnt_r[k]    <= CNT_ZERO;
        shadow_r[k] <= CNT_ZERO;
      end
      ovf_r        <= {NCNT{1'b0}};
      snap_valid_r <= 1'b0;
    end else begin
      for (int k = 0; k < NCNT; k++) begin
        cnt_r[k] <= cnt_nxt_s[k];
        if (snapshot_i) begin
          shadow_r[k] <= cnt_r[k];
        end
      end
      ovf_r <= ovf_r | ovf_set_s;
      if (snapshot_i) begin
        snap_valid_r <= 1'b1;
      end
    end
  end

  // Registered read port, one cycle behind rd_sel_i.
  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      rd_data_r <= CNT_ZERO;
    end else begin
      rd_data_r <= rd_mux_s;
    end
  end

  assign rd_data_o    = rd_data_r;
  assign overflow_o   = ovf_r;
  assign snap_valid_o = snap_valid_r;
  assign running_o    = running_r;

endmodule

// File: tb/tb_ucsbece154b_perf_counters.sv
// Directed self-checking bench for ucsbece154b_perf_counters (NUM_EVENTS=5, CNT_WIDTH=8).
// Expected values for the overflow scenario follow PERF_SATURATE_EN when it is defined.
module tb_ucsbece154b_perf_counters;

  localparam int NE = 5;
  localparam int CW = 8;
  localparam int SW = $clog2(NE + 1);

  logic          clk;
  logic          reset;
  logic          start_i;
  logic          stop_i;
  logic          clear_i;
  logic          snapshot_i;
  logic [NE-1:0] event_i;
  logic [SW-1:0] rd_sel_i;
  logic [CW-1:0] rd_data_o;
  logic [NE:0]   overflow_o;
  logic          snap_valid_o;
  logic          running_o;

  int checks;
  int failures;

  ucsbece154b_perf_counters #(.NUM_EVENTS(NE), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .stop_i(stop_i), .clear_i(clear_i),
    .snapshot_i(snapshot_i), .event_i(event_i), .rd_sel_i(rd_sel_i), .rd_data_o(rd_data_o),
    .overflow_o(overflow_o), .snap_valid_o(snap_valid_o), .running_o(running_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_sel(input int sel, output logic [CW-1:0] val);
    rd_sel_i = SW'(sel);
    step();
    val = rd_data_o;
  endtask

  task automatic pulse_clear();
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (rd_data_o !== 8'd0) begin failures++; $display("FAIL reset_rd_data got=%0d exp=0", rd_data_o); end
    checks++;
    if (overflow_o !== 6'd0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow_o); end
    checks++;
    if (snap_valid_o !== 1'b0) begin failures++; $display("FAIL reset_snap_valid got=%b exp=0", snap_valid_o); end
    checks++;
    if (running_o !== 1'b0) begin failures++; $display("FAIL reset_running got=%b exp=0", running_o); end
  endtask

  task automatic test_cycle_count();
    logic [CW-1:0] v;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    checks++;
    if (running_o !== 1'b1) begin failures++; $display("FAIL cyc_running got=%b exp=1", running_o); end
    repeat (9) step();
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
    checks++;
    if (running_o !== 1'b0) begin failures++; $display("FAIL cyc_frozen got=%b exp=0", running_o); end
    snapshot_i = 1'b1;
    step();
    snapshot_i = 1'b0;
    checks++;
    if (snap_valid_o !== 1'b1) begin failures++; $display("FAIL cyc_snap_valid got=%b exp=1", snap_valid_o); end
    read_sel(0, v);
    checks++;
    if (v !== 8'd10) begin failures++; $display("FAIL cyc_sel0 got=%0d exp=10", v); end
    for (int s = 1; s <= NE; s++) begin
      read_sel(s, v);
      checks++;
      if (v !== 8'd0) begin failures++; $display("FAIL cyc_idle_chan sel=%0d got=%0d exp=0", s, v); end
    end
    // Selects past the last channel read zero even while shadows hold data.
    for (int s = NE + 1; s < (1 << SW); s++) begin
      read_sel(s, v);
      checks++;
      if (v !== 8'd0) begin failures++; $display("FAIL cyc_bad_sel sel=%0d got=%0d exp=0", s, v); end
    end
  endtask

  task automatic test_events();
    logic [CW-1:0] v;
    pulse_clear();
    event_i = 5'b00101;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    event_i = 5'b00101;
    step();
    event_i = 5'b00001;
    repeat (4) step();
    event_i = 5'b00000;
    step();
    event_i = 5'b00101;
    stop_i  = 1'b1;
    step();
    stop_i  = 1'b0;
    event_i = 5'b00000;
    snapshot_i = 1'b1;
    step();
    snapshot_i = 1'b0;
    read_sel(1, v);
    checks++;
    if (v !== 8'd6) begin failures++; $display("FAIL ev_chan1 got=%0d exp=6", v); end
    read_sel(3, v);
    checks++;
    if (v !== 8'd2) begin failures++; $display("FAIL ev_chan3 got=%0d exp=2", v); end
    read_sel(0, v);
    checks++;
    if (v !== 8'd7) begin failures++; $display("FAIL ev_cycles got=%0d exp=7", v); end
    read_sel(2, v);
    checks++;
    if (v !== 8'd0) begin failures++; $display("FAIL ev_chan2 got=%0d exp=0", v); end
  endtask

  task automatic test_snapshot_same_cycle();
    logic [CW-1:0] v;
    pulse_clear();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    event_i = 5'b00001;
    repeat (5) step();
    snapshot_i = 1'b1;
    step();
    snapshot_i = 1'b0;
    event_i = 5'b00000;
    read_sel(1, v);
    checks++;
    if (v !== 8'd5) begin failures++; $display("FAIL snap_first got=%0d exp=5", v); end
    snapshot_i = 1'b1;
    step();
    snapshot_i = 1'b0;
    read_sel(1, v);
    checks++;
    if (v !== 8'd6) begin failures++; $display("FAIL snap_second got=%0d exp=6", v); end
  endtask

  task automatic test_overflow();
    logic [CW-1:0] v;
    logic [CW-1:0] exp_chan;
    logic [CW-1:0] exp_cyc;
`ifdef PERF_SATURATE_EN
    exp_chan = 8'd255;
    exp_cyc  = 8'd255;
`else
    exp_chan = 8'd4;
    exp_cyc  = 8'd5;
`endif
    pulse_clear();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    event_i = 5'b00010;
    repeat (260) step();
    event_i = 5'b00000;
    stop_i  = 1'b1;
    step();
    stop_i  = 1'b0;
    snapshot_i = 1'b1;
    step();
    snapshot_i = 1'b0;
    read_sel(2, v);
    checks++;
    if (v !== exp_chan) begin failures++; $display("FAIL ovf_chan2 got=%0d exp=%0d", v, exp_chan); end
    read_sel(0, v);
    checks++;
    if (v !== exp_cyc) begin failures++; $display("FAIL ovf_cycles got=%0d exp=%0d", v, exp_cyc); end
    checks++;
    if (overflow_o !== 6'b000101) begin failures++; $display("FAIL ovf_flags got=%b exp=000101", overflow_o); end
  endtask

  task automatic test_clear_snapshot();
    logic [CW-1:0] v;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    checks++;
    if (running_o !== 1'b1) begin failures++; $display("FAIL clr_resume got=%b exp=1", running_o); end
    event_i = 5'b11111;
    repeat (3) step();
    clear_i    = 1'b1;
    snapshot_i = 1'b1;
    step();
    clear_i    = 1'b0;
    snapshot_i = 1'b0;
    event_i    = 5'b00000;
    checks++;
    if (running_o !== 1'b0) begin failures++; $display("FAIL clr_running got=%b exp=0", running_o); end
    checks++;
    if (snap_valid_o !== 1'b0) begin failures++; $display("FAIL clr_snap_valid got=%b exp=0", snap_valid_o); end
    checks++;
    if (overflow_o !== 6'd0) begin failures++; $display("FAIL clr_overflow got=%b exp=0", overflow_o); end
    checks++;
    if (rd_data_o !== 8'd0) begin failures++; $display("FAIL clr_rd_data got=%0d exp=0", rd_data_o); end
    for (int s = 0; s <= NE + 1; s++) begin
      read_sel(s, v);
      checks++;
      if (v !== 8'd0) begin failures++; $display("FAIL clr_read sel=%0d got=%0d exp=0", s, v); end
    end
  endtask

  task automatic test_reset_midrun();
    logic [CW-1:0] v;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    event_i = 5'b11111;
    repeat (4) step();
    event_i = 5'b00000;
    snapshot_i = 1'b1;
    step();
    snapshot_i = 1'b0;
    read_sel(0, v);
    checks++;
    if (v !== 8'd4) begin failures++; $display("FAIL rst_pre_cycles got=%0d exp=4", v); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (running_o !== 1'b0) begin failures++; $display("FAIL rst_running got=%b exp=0", running_o); end
    checks++;
    if (snap_valid_o !== 1'b0) begin failures++; $display("FAIL rst_snap_valid got=%b exp=0", snap_valid_o); end
    checks++;
    if (overflow_o !== 6'd0) begin failures++; $display("FAIL rst_overflow got=%b exp=0", overflow_o); end
    checks++;
    if (rd_data_o !== 8'd0) begin failures++; $display("FAIL rst_rd_data got=%0d exp=0", rd_data_o); end
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
    checks++;
    if (running_o !== 1'b0) begin failures++; $display("FAIL rst_stop_idle got=%b exp=0", running_o); end
    snapshot_i = 1'b1;
    step();
    snapshot_i = 1'b0;
    read_sel(1, v);
    checks++;
    if (v !== 8'd0) begin failures++; $display("FAIL rst_live_zero got=%0d exp=0", v); end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    reset      = 1'b0;
    start_i    = 1'b0;
    stop_i     = 1'b0;
    clear_i    = 1'b0;
    snapshot_i = 1'b0;
    event_i    = 5'b00000;
    rd_sel_i   = 3'd0;
    test_reset();
    test_cycle_count();
    test_events();
    test_snapshot_same_cycle();
    test_overflow();
    test_clear_snapshot();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
